// File: rtl/layer3_result_scheduler_if.sv
// Bundle of the layer-3 result scheduler signals: pixel write handshake,
// SRAM write/read ports and the layer-4 tap stream. The master side is the
// scheduler and the slave side is its environment.
interface layer3_result_scheduler_if #(
  parameter int DATA_W = 128
);
  logic              frame_start;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              save_enable;
  logic [15:0]       save_row_addr;
  logic [15:0]       save_col_addr;
  logic [DATA_W-1:0] layer3_result_store_data_in;
  logic              win_ready;
  logic              layer3_result_read_signal;
  logic [15:0]       read_row_addr;
  logic [15:0]       read_col_addr;
  logic [DATA_W-1:0] layer3_result_output;
  logic              tap_valid;
  logic [DATA_W-1:0] tap_data;
  logic [3:0]        tap_idx;
  logic              tap_last;
  logic [15:0]       win_row;
  logic [15:0]       win_col;
  logic              busy;
  logic              frame_done;

  modport master (
    input  frame_start, wr_valid, wr_data, win_ready, layer3_result_output,
    output wr_ready, save_enable, save_row_addr, save_col_addr,
           layer3_result_store_data_in, layer3_result_read_signal,
           read_row_addr, read_col_addr, tap_valid, tap_data, tap_idx,
           tap_last, win_row, win_col, busy, frame_done
  );

  modport slave (
    output frame_start, wr_valid, wr_data, win_ready, layer3_result_output,
    input  wr_ready, save_enable, save_row_addr, save_col_addr,
           layer3_result_store_data_in, layer3_result_read_signal,
           read_row_addr, read_col_addr, tap_valid, tap_data, tap_idx,
           tap_last, win_row, win_col, busy, frame_done
  );
endinterface

// File: rtl/layer3_result_scheduler.sv
// Layer-3 result SRAM sequencer for one WIDTH x WIDTH frame. Raster-order
// pixels are written as they arrive; KERNEL x KERNEL windows are read out
// tap by tap as soon as every row a window covers has been written, so
// layer 4 overlaps with layer-3 output.
module layer3_result_scheduler #(
  parameter int WIDTH  = 14,
  parameter int KERNEL = 3,
  parameter int DATA_W = 128
) (
  input logic clk,
  input logic rst,
  layer3_result_scheduler_if.master bus
);

  localparam logic [15:0] PIX      = 16'(WIDTH * WIDTH);
  localparam logic [15:0] COL_LAST = 16'(WIDTH - 1);
  localparam logic [15:0] WIN_LAST = 16'(WIDTH - KERNEL);
  localparam logic [1:0]  K_LAST   = 2'(KERNEL - 1);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_FETCH, R_DONE} rstate_t;

  rstate_t           state;
  logic              busy;
  logic              frame_done;
  logic [15:0]       wr_cnt;
  logic [15:0]       wr_row;
  logic [15:0]       wr_col;
  logic [15:0]       win_row;
  logic [15:0]       win_col;
  logic [1:0]        ky;
  logic [1:0]        kx;
  logic [3:0]        k;
  logic              wr_fire;
  logic              rd_en;
  logic              row_ok;
  logic              tap_valid;
  logic [DATA_W-1:0] tap_data;
  logic [3:0]        tap_idx;
  logic              tap_last;

  assign k       = 4'(ky) * 4'd3 + 4'(kx);
  assign wr_fire = bus.wr_valid && bus.wr_ready;
  assign rd_en   = (state == R_FETCH);
  // Registered write count: a pixel written this cycle only counts next cycle,
  // so a read can never collide with the write of the same address.
  assign row_ok  = wr_cnt >= (win_row + 16'(KERNEL)) * 16'(WIDTH);

  assign bus.wr_ready                    = busy && (wr_cnt < PIX);
  assign bus.save_enable                 = wr_fire;
  assign bus.save_row_addr               = wr_row;
  assign bus.save_col_addr               = wr_col;
  assign bus.layer3_result_store_data_in = wr_fire ? bus.wr_data : '0;
  assign bus.layer3_result_read_signal   = rd_en;
  assign bus.read_row_addr               = win_row + 16'(ky);
  assign bus.read_col_addr               = win_col + 16'(kx);
  assign bus.tap_valid                   = tap_valid;
  assign bus.tap_data                    = tap_data;
  assign bus.tap_idx                     = tap_idx;
  assign bus.tap_last                    = tap_last;
  assign bus.win_row                     = win_row;
  assign bus.win_col                     = win_col;
  assign bus.busy                        = busy;
  assign bus.frame_done                  = frame_done;

  // Write-side raster address and accepted-pixel count; cleared per frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_cnt <= '0;
      wr_row <= '0;
      wr_col <= '0;
    end else if (state == R_DONE || (state == R_IDLE && bus.frame_start)) begin
      wr_cnt <= '0;
      wr_row <= '0;
      wr_col <= '0;
    end else if (wr_fire) begin
      wr_cnt <= wr_cnt + 16'd1;
      if (wr_col == COL_LAST) begin
        wr_col <= '0;
        wr_row <= wr_row + 16'd1;
      end else begin
        wr_col <= wr_col + 16'd1;
      end
    end
  end

  // Window walker: wait for readiness, fetch the taps, advance the origin.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= R_IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      win_row    <= '0;
      win_col    <= '0;
      ky         <= '0;
      kx         <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        R_IDLE: if (bus.frame_start) begin
          busy    <= 1'b1;
          win_row <= '0;
          win_col <= '0;
          state   <= R_WAIT;
        end
        R_WAIT: if (bus.win_ready && row_ok) begin
          ky    <= '0;
          kx    <= '0;
          state <= R_FETCH;
        end
        R_FETCH: begin
          if (kx == K_LAST) begin
            kx <= '0;
            ky <= ky + 2'd1;
          end else begin
            kx <= kx + 2'd1;
          end
          if (ky == K_LAST && kx == K_LAST) begin
            ky <= '0;
            if (win_col == WIN_LAST) begin
              win_col <= '0;
              win_row <= win_row + 16'd1;
            end else begin
              win_col <= win_col + 16'd1;
            end
            state <= (win_row == WIN_LAST && win_col == WIN_LAST) ? R_DONE : R_WAIT;
          end
        end
        R_DONE: begin
          frame_done <= 1'b1;
          busy       <= 1'b0;
          win_row    <= '0;
          win_col    <= '0;
          state      <= R_IDLE;
        end
        default: state <= R_IDLE;
      endcase
    end
  end

  // One-stage tap pipeline aligned with the SRAM read latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tap_valid <= 1'b0;
      tap_data  <= '0;
      tap_idx   <= '0;
      tap_last  <= 1'b0;
    end else begin
      tap_valid <= rd_en;
      tap_data  <= rd_en ? bus.layer3_result_output : '0;
      tap_idx   <= rd_en ? k : 4'd0;
      tap_last  <= rd_en && (k == 4'd8);
    end
  end

endmodule

// File: tb/tb_layer3_result_scheduler.sv
// Bench for layer3_result_scheduler: a negedge SRAM model plus a reference
// of the window/tap order derived from raster indices.
module tb_layer3_result_scheduler;
  localparam int W   = 14;
  localparam int K   = 3;
  localparam int NW  = W - K + 1;
  localparam int NT  = NW * NW * 9;
  localparam int DW  = 128;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  layer3_result_scheduler_if #(.DATA_W(DW)) bus ();
  layer3_result_scheduler #(.WIDTH(W), .KERNEL(K), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .bus(bus));

  int errors = 0, checks = 0;
  bit mon_on = 1'b0;
  int acc, strobes, taps, lasts, dones, cyc = 0;
  int first_strobe_cyc, acc42_cyc, last_tap_cyc, done_cyc;
  logic [DW-1:0] px [W*W];
  logic [DW-1:0] mem [W][W];
  logic [DW-1:0] tap_d [NT];
  int rd_r [NT];
  int rd_c [NT];

  function automatic logic [362:0] all_outs();
    return {bus.wr_ready, bus.save_enable, bus.save_row_addr, bus.save_col_addr,
            bus.layer3_result_store_data_in, bus.layer3_result_read_signal,
            bus.read_row_addr, bus.read_col_addr, bus.tap_valid, bus.tap_data,
            bus.tap_idx, bus.tap_last, bus.win_row, bus.win_col, bus.busy, bus.frame_done};
  endfunction

  task automatic clear_model();
    acc = 0; strobes = 0; taps = 0; lasts = 0; dones = 0;
    first_strobe_cyc = -1; acc42_cyc = -1; last_tap_cyc = -1; done_cyc = -1;
  endtask

  // SRAM model and scoreboard, evaluated mid-cycle on the SRAM clock edge.
  always @(negedge clk) begin
    int s, w, k, er, ec, ra, ca;
    logic [DW-1:0] exp_d;
    cyc++;
    if (mon_on) begin
      if (bus.layer3_result_read_signal) begin
        s = strobes; w = s / 9; k = s % 9;
        er = w / NW + k / K; ec = w % NW + k % K;
        ra = int'(bus.read_row_addr); ca = int'(bus.read_col_addr);
        checks++;
        if (s >= NT || ra != er || ca != ec) begin
          errors++;
          $display("FAIL read_addr strobe=%0d got (%0d,%0d) want (%0d,%0d)", s, ra, ca, er, ec);
        end
        checks++;
        if (acc < (w / NW + K) * W) begin
          errors++;
          $display("FAIL read_before_ready strobe=%0d written=%0d need=%0d", s, acc, (w / NW + K) * W);
        end
        if (ra < W && ca < W) bus.layer3_result_output = mem[ra][ca];
        else bus.layer3_result_output = '0;
        if (s < NT) begin rd_r[s] = ra; rd_c[s] = ca; end
        if (s == 0) first_strobe_cyc = cyc;
        strobes++;
      end
      if (bus.tap_valid) begin
        s = taps; w = s / 9; k = s % 9;
        checks++;
        if (s >= NT) begin
          errors++;
          $display("FAIL extra_tap tap=%0d", s);
        end else begin
          exp_d = px[(w / NW + k / K) * W + w % NW + k % K];
          if (bus.tap_data !== exp_d || bus.tap_idx !== 4'(k) || bus.tap_last !== (k == 8)) begin
            errors++;
            $display("FAIL tap tap=%0d got data=%0h idx=%0d last=%0b want data=%0h idx=%0d last=%0b",
                     s, bus.tap_data, bus.tap_idx, bus.tap_last, exp_d, k, k == 8);
          end
          tap_d[s] = bus.tap_data;
        end
        if (bus.tap_last) begin lasts++; last_tap_cyc = cyc; end
        taps++;
      end
      if (bus.save_enable) begin
        checks++;
        if (acc >= W * W || int'(bus.save_row_addr) != acc / W || int'(bus.save_col_addr) != acc % W ||
            bus.layer3_result_store_data_in !== bus.wr_data) begin
          errors++;
          $display("FAIL save pix=%0d got (%0d,%0d) data=%0h want (%0d,%0d) data=%0h", acc,
                   bus.save_row_addr, bus.save_col_addr, bus.layer3_result_store_data_in,
                   acc / W, acc % W, bus.wr_data);
        end
        if (acc < W * W) px[acc] = bus.wr_data;
        if (bus.save_row_addr < 16'(W) && bus.save_col_addr < 16'(W))
          mem[bus.save_row_addr][bus.save_col_addr] = bus.layer3_result_store_data_in;
        if (acc == 41) acc42_cyc = cyc;
        acc++;
      end
      if (bus.frame_done) begin
        checks++;
        if (bus.busy !== 1'b0) begin
          errors++;
          $display("FAIL done_busy busy=%0b want 0", bus.busy);
        end
        dones++;
        done_cyc = cyc;
      end
    end
  end

  task automatic start_frame();
    @(posedge clk); #1 bus.frame_start = 1'b1;
    @(posedge clk); #1 bus.frame_start = 1'b0;
  endtask

  task automatic drive_writes(input int n, input int pct, input bit seq, output int sent);
    int guard = 0;
    sent = 0;
    while (sent < n && guard < 20000) begin
      @(posedge clk); #1;
      bus.wr_valid = ($urandom_range(99) < pct);
      bus.wr_data  = seq ? DW'(acc) : {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      if (bus.wr_valid && bus.wr_ready) sent++;
      guard++;
    end
    @(posedge clk); #1 bus.wr_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk); #1;
      if (dones > 0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; mon_on = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      bus.frame_start = 1'($urandom_range(1));
      bus.wr_valid    = 1'($urandom_range(1));
      bus.win_ready   = 1'($urandom_range(1));
      bus.wr_data     = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      checks++;
      if (all_outs() !== '0) begin
        errors++;
        $display("FAIL reset_outputs got %0h want 0", all_outs());
      end
    end
    bus.frame_start = 1'b0; bus.wr_valid = 1'b0; bus.win_ready = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset busy=%0b wr_ready=%0b want 0 0", bus.busy, bus.wr_ready);
    end
    start_frame();
    checks++;
    if (bus.busy !== 1'b1 || bus.wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL frame_start busy=%0b wr_ready=%0b want 1 1", bus.busy, bus.wr_ready);
    end
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
  endtask

  task automatic test_full_frame();
    int sent;
    bit ok;
    int exp0 [9] = '{0, 1, 2, 14, 15, 16, 28, 29, 30};
    clear_model(); mon_on = 1'b1; bus.win_ready = 1'b1;
    start_frame();
    fork
      drive_writes(W * W, 70, 1'b1, sent);
      wait_done(6000, ok);
    join
    repeat (3) @(negedge clk);
    checks++;
    if (!ok || sent != W * W || acc != W * W) begin
      errors++;
      $display("FAIL full_complete done=%0b sent=%0d saved=%0d want 1 196 196", ok, sent, acc);
    end
    checks++;
    if (taps != NT || strobes != NT || lasts != NW * NW || dones != 1) begin
      errors++;
      $display("FAIL full_counts taps=%0d strobes=%0d lasts=%0d dones=%0d want 1296 1296 144 1",
               taps, strobes, lasts, dones);
    end
    checks++;
    if (first_strobe_cyc <= acc42_cyc) begin
      errors++;
      $display("FAIL first_read cycle=%0d want after %0d", first_strobe_cyc, acc42_cyc);
    end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (tap_d[i] !== DW'(exp0[i])) begin
        errors++;
        $display("FAIL win0_tap%0d got %0h want %0d", i, tap_d[i], exp0[i]);
      end
    end
    checks++;
    if (rd_r[107] != 2 || rd_c[107] != 13 || rd_r[108] != 1 || rd_c[108] != 0) begin
      errors++;
      $display("FAIL wrap got (%0d,%0d)->(%0d,%0d) want (2,13)->(1,0)", rd_r[107], rd_c[107], rd_r[108], rd_c[108]);
    end
    checks++;
    if (rd_r[NT-1] != 13 || rd_c[NT-1] != 13 || tap_d[NT-1] !== DW'(195)) begin
      errors++;
      $display("FAIL last_tap got (%0d,%0d) data=%0h want (13,13) 195", rd_r[NT-1], rd_c[NT-1], tap_d[NT-1]);
    end
    checks++;
    if (done_cyc != last_tap_cyc + 1) begin
      errors++;
      $display("FAIL done_timing done=%0d want %0d", done_cyc, last_tap_cyc + 1);
    end
  endtask

  task automatic test_writer_stall();
    int sent;
    bit ok;
    clear_model(); bus.win_ready = 1'b1;
    start_frame();
    drive_writes(41, 100, 1'b0, sent);
    repeat (50) @(negedge clk);
    checks++;
    if (strobes != 0) begin
      errors++;
      $display("FAIL stall_no_read strobes=%0d want 0", strobes);
    end
    drive_writes(1, 100, 1'b0, sent);
    for (int i = 0; i < 6 && strobes == 0; i++) begin @(negedge clk); #1; end
    checks++;
    if (first_strobe_cyc < acc42_cyc + 1 || first_strobe_cyc > acc42_cyc + 2) begin
      errors++;
      $display("FAIL stall_resume first_read=%0d want %0d..%0d", first_strobe_cyc, acc42_cyc + 1, acc42_cyc + 2);
    end
    fork
      drive_writes(W * W - 42, 60, 1'b0, sent);
      wait_done(6000, ok);
    join
    checks++;
    if (!ok || acc != W * W || taps != NT || lasts != NW * NW) begin
      errors++;
      $display("FAIL stall_frame done=%0b saved=%0d taps=%0d lasts=%0d want 1 196 1296 144", ok, acc, taps, lasts);
    end
  endtask

  task automatic test_backpressure();
    int sent;
    bit ok;
    clear_model(); bus.win_ready = 1'b1;
    start_frame();
    fork
      drive_writes(42, 100, 1'b0, sent);
      begin
        for (int i = 0; i < 400 && strobes == 0; i++) begin @(negedge clk); #1; end
        bus.win_ready = 1'b0;
      end
    join
    drive_writes(W * W - 42, 100, 1'b0, sent);
    repeat (20) @(negedge clk);
    checks++;
    if (strobes != 9 || taps != 9 || acc != W * W) begin
      errors++;
      $display("FAIL bp_hold strobes=%0d taps=%0d saved=%0d want 9 9 196", strobes, taps, acc);
    end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1 bus.wr_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.wr_ready !== 1'b0 || bus.save_enable !== 1'b0) begin
        errors++;
        $display("FAIL bp_overflow wr_ready=%0b save=%0b want 0 0", bus.wr_ready, bus.save_enable);
      end
    end
    @(posedge clk); #1 bus.wr_valid = 1'b0; bus.win_ready = 1'b1;
    wait_done(3000, ok);
    checks++;
    if (!ok || rd_r[9] != 0 || rd_c[9] != 1 || taps != NT) begin
      errors++;
      $display("FAIL bp_resume done=%0b win1=(%0d,%0d) taps=%0d want 1 (0,1) 1296", ok, rd_r[9], rd_c[9], taps);
    end
  endtask

  task automatic test_reset_mid_fetch();
    int sent;
    clear_model(); bus.win_ready = 1'b1;
    start_frame();
    drive_writes(W * W, 100, 1'b0, sent);
    for (int i = 0; i < 3000 && strobes != 905; i++) begin @(negedge clk); #1; end
    mon_on = 1'b0;
    checks++;
    if (strobes != 905 || bus.layer3_result_read_signal !== 1'b1) begin
      errors++;
      $display("FAIL mid_setup strobes=%0d rd=%0b want 905 1", strobes, bus.layer3_result_read_signal);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (all_outs() !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs got %0h want 0", all_outs());
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (bus.frame_done !== 1'b0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset_hold done=%0b busy=%0b want 0 0", bus.frame_done, bus.busy);
      end
    end
    rst = 1'b1;
  endtask

  task automatic test_frame_start_ignored();
    int sent;
    bit ok;
    @(negedge clk);
    clear_model(); mon_on = 1'b1; bus.win_ready = 1'b1;
    start_frame();
    drive_writes(5, 100, 1'b0, sent);
    start_frame();
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1 || bus.save_row_addr !== 16'd0 || bus.save_col_addr !== 16'd5 || acc != 5) begin
      errors++;
      $display("FAIL restart_ignored busy=%0b addr=(%0d,%0d) saved=%0d want 1 (0,5) 5",
               bus.busy, bus.save_row_addr, bus.save_col_addr, acc);
    end
    fork
      drive_writes(W * W - 5, 50, 1'b0, sent);
      wait_done(8000, ok);
      for (int i = 0; i < 8000 && dones == 0; i++) begin
        @(posedge clk); #1 bus.win_ready = 1'($urandom_range(1));
      end
    join
    bus.win_ready = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (!ok || acc != W * W || taps != NT || lasts != NW * NW || dones != 1) begin
      errors++;
      $display("FAIL restart_frame done=%0b saved=%0d taps=%0d lasts=%0d dones=%0d want 1 196 1296 144 1",
               ok, acc, taps, lasts, dones);
    end
  endtask

  initial begin
    bus.frame_start = 1'b0; bus.wr_valid = 1'b0; bus.wr_data = '0;
    bus.win_ready = 1'b0; bus.layer3_result_output = '0;
    clear_model();
    test_reset();
    test_full_frame();
    test_writer_stall();
    test_backpressure();
    test_reset_mid_fetch();
    test_frame_start_ignored();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout after %0d cycles", cyc);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/layer3_result_scheduler.md
Name: layer3_result_scheduler

Overview:
- Sequences the dual-port layer-3 result SRAM for one 14x14 frame.
- Write side: accepts layer-3 pixels in raster order over a valid/ready handshake and generates save addresses.
- Read side: walks all 3x3 windows for layer 4 and issues 9 tap reads per window.
- A window is released only after every row it covers has been written, so layer 4 overlaps with layer-3 output.

Parameters:
- WIDTH, 14, feature-map side length (rows = cols).
- KERNEL, 3, window side length; windows per axis = WIDTH-KERNEL+1.
- DATA_W, 128, pixel width (matches `LAYER3_OUTPUT_LENGTH).

Ports:
- clk  in  1  single system clock; the SRAM is clocked on ~clk.
- rst  in  1  reset, asynchronous, active-low.
- frame_start  in  1  one-cycle pulse that begins a frame; ignored unless idle.
- wr_valid  in  1  layer-3 pixel valid.
- wr_ready  out  1  scheduler accepts a pixel.
- wr_data  in  DATA_W  layer-3 pixel.
- save_enable  out  1  SRAM write strobe.
- save_row_addr  out  16  SRAM write row.
- save_col_addr  out  16  SRAM write col.
- layer3_result_store_data_in  out  DATA_W  SRAM write data.
- win_ready  in  1  layer 4 can take the next window.
- layer3_result_read_signal  out  1  SRAM read strobe.
- read_row_addr  out  16  SRAM read row.
- read_col_addr  out  16  SRAM read col.
- layer3_result_output  in  DATA_W  SRAM read data.
- tap_valid  out  1  tap_data holds a window tap.
- tap_data  out  DATA_W  tap pixel.
- tap_idx  out  4  tap index 0..8, equal to ky*3+kx.
- tap_last  out  1  tap 8 of the window.
- win_row  out  16  row of the current window origin.
- win_col  out  16  col of the current window origin.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse after the last tap.

Behaviour:
- Reset (rst low, async):
  - FSM goes to R_IDLE; all counters clear.
  - Every output is 0; tap_data is 0.
  - Reset mid-frame abandons the frame with no done pulse.
- Write side:
  - wr_ready = busy && wr_cnt < WIDTH*WIDTH (196).
  - On wr_valid && wr_ready:
    - save_enable=1 combinationally.
    - Address is (wr_row, wr_col); data = wr_data.
    - On the clock edge, wr_col increments; at WIDTH-1 it wraps to 0 and wr_row increments.
    - wr_cnt increments.
  - Otherwise save_enable=0 and the data output is 0.
- Readiness rule: window row r may start only when wr_cnt >= (r+KERNEL)*WIDTH. Use the registered wr_cnt, so a pixel written in cycle t is readable from cycle t+1. This guarantees a read never hits an unwritten or same-cycle-written address.
- Read FSM states:
  - R_IDLE: on frame_start, set busy=1, clear win_row/win_col, go to R_WAIT. frame_start in any other state is ignored.
  - R_WAIT: move to R_FETCH when win_ready && readiness rule holds for win_row; the tap counter k resets to 0.
  - R_FETCH, 9 cycles:
    - Each cycle: layer3_result_read_signal=1, read_row_addr=win_row+k/3, read_col_addr=win_col+k%3; k increments.
    - After k=8:
      - Advance win_col; at WIDTH-KERNEL it wraps to 0 and win_row increments.
      - If the window was (11,11), go to R_DONE; otherwise go to R_WAIT.
  - R_DONE: frame_done=1 for one cycle; busy=0; wr_cnt clears; go to R_IDLE.
- Read latency: the strobe issued in cycle t produces tap_valid=1 in cycle t+1, with tap_data = layer3_result_output and tap_idx/tap_last pipelined one stage. tap_valid is 0 otherwise.
- There are no back-to-back windows without an R_WAIT cycle. Minimum window period is 10 cycles.
- win_ready is sampled only in R_WAIT; deasserting it mid-fetch does not stall the window.
- Write and read proceed in the same cycle independently.
- Writes beyond 196 are refused; wr_ready stays 0 until the next frame.

Test Plan:
- Reset: hold rst low with toggling inputs -> all outputs 0, wr_ready 0, FSM R_IDLE. Release, pulse frame_start -> busy=1 and wr_ready=1 next cycle.
- Full frame: write 196 pixels with data = row*14+col, win_ready=1 -> first read strobe no earlier than the cycle after the 42nd accepted write. Window (0,0) taps read 0,1,2,14,15,16,28,29,30. Totals: 1296 tap_valid, 144 tap_last, 1 frame_done.
- Writer stall: stop after 41 writes -> no read strobe for 50 cycles. Write the 42nd pixel -> fetch of (0,0) begins within 2 cycles.
- Consumer backpressure: win_ready=0 after window 0 -> no read strobes; writes continue to 196, then wr_ready=0. Raise win_ready -> window (0,1) fetched.
- Wrap: after window (0,11) (last tap reads addr (2,13)), next window is (1,0). Final window (11,11) tap_last reads (13,13), data 195; frame_done the following cycle.
- Reset mid-fetch at tap 4 -> outputs 0 immediately. frame_start while busy -> ignored, counters unchanged.
